blk_xfer_ctrl: RTL and testbench

BLK_XFER_CTRL -- requirements
Module: blk_xfer_ctrl

---
 rtl/blk_xfer_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_blk_xfer_ctrl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/blk_xfer_ctrl.sv
// rtl/blk_xfer_ctrl.sv - multi-block SD data transfer sequencer
// Optional feature macro: BLK_XFER_CTRL_RETRY_EN (per-block retry after a CRC failure)
module blk_xfer_ctrl #(
  parameter int BLK_CNT_W    = 8,
  parameter int BUSY_TIMEOUT = 250000,
  parameter int MAX_RETRY    = 3
) (
  input  logic                 iclk,
  input  logic                 irst,
  input  logic                 istart,
  input  logic                 iwrite,
  input  logic [BLK_CNT_W-1:0] iblk_cnt,
  input  logic                 iabort,
  input  logic                 idat0,
  output logic                 odrv_start_read,
  output logic                 odrv_start_write,
  input  logic                 idrv_done,
  input  logic                 idrv_crc_fail,
  output logic [BLK_CNT_W-1:0] oblk_idx,
  output logic                 obusy,
  output logic                 odone,
  output logic [1:0]           oerr
);

  // Timeout counter only ever needs to hold values up to BUSY_TIMEOUT.
  localparam int TO_W = (BUSY_TIMEOUT < 2) ? 1 : $clog2(BUSY_TIMEOUT + 1);

  localparam logic [1:0] ERR_OK      = 2'd0;
  localparam logic [1:0] ERR_CRC     = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;
  localparam logic [1:0] ERR_ABORT   = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_WAIT_DRV  = 3'd2,
    S_WAIT_BUSY = 3'd3,
    S_NEXT      = 3'd4,
    S_FINISH    = 3'd5
  } state_t;

  state_t               r_state;
  logic                 r_write;
  logic [BLK_CNT_W-1:0] r_cnt;
  logic [BLK_CNT_W-1:0] r_idx;
  logic [TO_W-1:0]      r_to_cnt;
  logic                 r_start_rd;
  logic                 r_start_wr;
  logic                 r_done;
  logic [1:0]           r_err;

`ifdef BLK_XFER_CTRL_RETRY_EN
  localparam int RT_W = (MAX_RETRY < 2) ? 1 : $clog2(MAX_RETRY + 1);
  logic [RT_W-1:0]      r_retry;
`endif

  logic w_last_blk;
  logic w_to_hit;
  logic w_to_sat;

  // r_cnt is never zero outside IDLE/FINISH, so r_cnt - 1 cannot underflow where it is used.
  assign w_last_blk = (r_idx == (r_cnt - {{(BLK_CNT_W-1){1'b0}}, 1'b1}));
  // The counter holds the number of completed low cycles; the current cycle is the last allowed one.
  assign w_to_hit   = (r_to_cnt == TO_W'(BUSY_TIMEOUT - 1));
  assign w_to_sat   = (r_to_cnt == TO_W'(BUSY_TIMEOUT));

  assign odrv_start_read  = r_start_rd;
  assign odrv_start_write = r_start_wr;
  assign oblk_idx         = r_idx;
  assign obusy            = (r_state != S_IDLE);
  assign odone            = r_done;
  assign oerr             = r_err;

  // Transfer sequencer: state, latched request, counters and all registered outputs.
  always_ff @(posedge iclk) begin
    if (irst) begin
      r_state    <= S_IDLE;
      r_write    <= 1'b0;
      r_cnt      <= '0;
      r_idx      <= '0;
      r_to_cnt   <= '0;
      r_start_rd <= 1'b0;
      r_start_wr <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= ERR_OK;
`ifdef BLK_XFER_CTRL_RETRY_EN
      r_retry    <= '0;
`endif
    end else begin
      // Pulse outputs default low so each assertion lasts exactly one cycle.
      r_start_rd <= 1'b0;
      r_start_wr <= 1'b0;
      r_done     <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (istart) begin
            r_write <= iwrite;
            r_cnt   <= iblk_cnt;
            r_idx   <= '0;
            r_err   <= ERR_OK;
`ifdef BLK_XFER_CTRL_RETRY_EN
            r_retry <= '0;
`endif
            // A zero-block request completes without ever touching the DAT driver.
            if (iblk_cnt == '0) begin
              r_state <= S_FINISH;
            end else begin
              r_state <= S_START;
            end
          end
        end

        S_START: begin
          if (iabort) begin
            r_err   <= ERR_ABORT;
            r_state <= S_FINISH;
          end else begin
            if (r_write) begin
              r_start_wr <= 1'b1;
            end else begin
              r_start_rd <= 1'b1;
            end
            r_state <= S_WAIT_DRV;
          end
        end

        S_WAIT_DRV: begin
          // Abort wins over a block completion reported in the same cycle.
          if (iabort) begin
            r_err   <= ERR_ABORT;
            r_state <= S_FINISH;
          end else if (idrv_done) begin
            if (idrv_crc_fail) begin
`ifdef BLK_XFER_CTRL_RETRY_EN
              if (r_retry < RT_W'(MAX_RETRY)) begin
                r_retry <= r_retry + {{(RT_W-1){1'b0}}, 1'b1};
                r_state <= S_START;
              end else begin
                r_err   <= ERR_CRC;
                r_state <= S_FINISH;
              end
`else
              r_err   <= ERR_CRC;
              r_state <= S_FINISH;
`endif
            end else if (r_write) begin
              r_to_cnt <= '0;
              r_state  <= S_WAIT_BUSY;
            end else begin
              r_state <= S_NEXT;
            end
          end
        end

        S_WAIT_BUSY: begin
          // Card holds DAT0 low while programming the block it just received.
          if (iabort) begin
            r_err   <= ERR_ABORT;
            r_state <= S_FINISH;
          end else if (idat0) begin
            r_state <= S_NEXT;
          end else if (w_to_hit) begin
            r_err   <= ERR_TIMEOUT;
            r_state <= S_FINISH;
          end else if (!w_to_sat) begin
            r_to_cnt <= r_to_cnt + {{(TO_W-1){1'b0}}, 1'b1};
          end
        end

        S_NEXT: begin
          if (iabort) begin
            r_err   <= ERR_ABORT;
            r_state <= S_FINISH;
          end else if (w_last_blk) begin
            r_err   <= ERR_OK;
            r_state <= S_FINISH;
          end else begin
            r_idx   <= r_idx + {{(BLK_CNT_W-1){1'b0}}, 1'b1};
`ifdef BLK_XFER_CTRL_RETRY_EN
            r_retry <= '0;
`endif
            r_state <= S_START;
          end
        end

        S_FINISH: begin
          r_done  <= 1'b1;
          r_state <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_blk_xfer_ctrl.sv
// tb/tb_blk_xfer_ctrl.sv - self-checking bench for blk_xfer_ctrl
module tb_blk_xfer_ctrl;

  localparam int BW = 8;
  localparam int TO = 100;
  localparam int MR = 3;
`ifdef BLK_XFER_CTRL_RETRY_EN
  localparam int CRC_STARTS = MR + 1;
`else
  localparam int CRC_STARTS = 1;
`endif

  logic          iclk = 1'b0;
  logic          irst = 1'b1;
  logic          istart = 1'b0;
  logic          iwrite = 1'b0;
  logic [BW-1:0] iblk_cnt = '0;
  logic          iabort = 1'b0;
  logic          idat0 = 1'b1;
  logic          idrv_done = 1'b0;
  logic          idrv_crc_fail = 1'b0;
  logic          odrv_start_read;
  logic          odrv_start_write;
  logic [BW-1:0] oblk_idx;
  logic          obusy;
  logic          odone;
  logic [1:0]    oerr;

  blk_xfer_ctrl #(.BLK_CNT_W(BW), .BUSY_TIMEOUT(TO), .MAX_RETRY(MR)) dut (
    .iclk(iclk), .irst(irst), .istart(istart), .iwrite(iwrite), .iblk_cnt(iblk_cnt),
    .iabort(iabort), .idat0(idat0), .odrv_start_read(odrv_start_read),
    .odrv_start_write(odrv_start_write), .idrv_done(idrv_done),
    .idrv_crc_fail(idrv_crc_fail), .oblk_idx(oblk_idx), .obusy(obusy),
    .odone(odone), .oerr(oerr)
  );

  always #5 iclk = ~iclk;

  int cyc = 0;
  always @(posedge iclk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    bit wr; int cnt; int delay; bit crc; int busy; int abort_idx; bit mid_start;
    int exp_starts; int exp_err; int exp_lat; int exp_to_lat;
  } vec_t;

  typedef struct {
    bit wr; int starts; int err; int start_cyc; int lat; int to_lat;
  } exp_t;

  exp_t sb[$];

  // Driver/card model configuration, written by the main sequence while the DUT is idle.
  int cfg_delay = 10;
  bit cfg_crc = 1'b0;
  int cfg_busy = 0;
  int cfg_abort_idx = -1;

  // Model and monitor state, owned by the negedge block below.
  int   drv_cnt = 0;
  int   busy_cnt = 0;
  int   exp_idx = 0;
  int   n_rd = 0;
  int   n_wr = 0;
  int   snap_rd = 0;
  int   snap_wr = 0;
  int   done_cnt = 0;
  int   last_done_cyc = 0;
  bit   cur_wr = 1'b0;
  bit   prev_odone = 1'b0;
  exp_t mon_e;

  // DAT driver + card busy model, start-pulse checker and odone scoreboard.
  always @(negedge iclk) begin
    idrv_done = 1'b0;
    idrv_crc_fail = 1'b0;
    iabort = 1'b0;
    if (busy_cnt > 0) begin
      busy_cnt--;
      if (busy_cnt == 0) idat0 = 1'b1;
    end
    if (drv_cnt > 0) begin
      drv_cnt--;
      if (drv_cnt == 0) begin
        idrv_done = 1'b1;
        idrv_crc_fail = cfg_crc;
        last_done_cyc = cyc;
        if (cfg_abort_idx == exp_idx) begin
          iabort = 1'b1;
        end else if (!cfg_crc) begin
          exp_idx++;
          if (cur_wr && cfg_busy > 0) begin
            idat0 = 1'b0;
            busy_cnt = cfg_busy;
          end
        end
      end
    end
    if (odrv_start_read || odrv_start_write) begin
      chk("start_exclusive", int'(odrv_start_read & odrv_start_write), 0);
      chk("blk_idx_at_start", int'(oblk_idx), exp_idx);
      if (odrv_start_read) n_rd++;
      if (odrv_start_write) n_wr++;
      cur_wr = odrv_start_write;
      drv_cnt = cfg_delay;
    end
    if (odone) begin
      chk("odone_one_cycle", int'(prev_odone), 0);
      if (sb.size() == 0) begin
        chk("unexpected_odone", 1, 0);
      end else begin
        mon_e = sb.pop_front();
        chk("oerr_at_done", int'(oerr), mon_e.err);
        chk("starts_dir", mon_e.wr ? (n_wr - snap_wr) : (n_rd - snap_rd), mon_e.starts);
        chk("starts_other_dir", mon_e.wr ? (n_rd - snap_rd) : (n_wr - snap_wr), 0);
        if (mon_e.lat >= 0) chk("start_to_done_lat", cyc - mon_e.start_cyc, mon_e.lat);
        if (mon_e.to_lat >= 0) chk("busy_timeout_lat", cyc - last_done_cyc, mon_e.to_lat);
      end
      snap_rd = n_rd;
      snap_wr = n_wr;
      exp_idx = 0;
      done_cnt++;
    end
    prev_odone = odone;
  end

  initial begin
    vec_t tv[10];
    int   base;
    int   budget;

    //         wr cnt  dly crc busy abrt mid starts      err lat to_lat
    tv[0] = '{1'b0, 3,   10, 1'b0, 0,   -1, 1'b0, 3,          0, -1, -1};
    tv[1] = '{1'b1, 2,   10, 1'b0, 50,  -1, 1'b0, 2,          0, -1, -1};
    tv[2] = '{1'b1, 1,   10, 1'b0, 150, -1, 1'b0, 1,          2, -1, TO + 2};
    tv[3] = '{1'b0, 1,   10, 1'b1, 0,   -1, 1'b0, CRC_STARTS, 1, -1, -1};
    tv[4] = '{1'b0, 4,   10, 1'b0, 0,    1, 1'b0, 2,          3, -1, -1};
    tv[5] = '{1'b0, 0,   10, 1'b0, 0,   -1, 1'b0, 0,          0,  2, -1};
    tv[6] = '{1'b0, 2,   10, 1'b0, 0,   -1, 1'b1, 2,          0, -1, -1};
    tv[7] = '{1'b1, 3,    3, 1'b0, 0,   -1, 1'b0, 3,          0, -1, -1};
    tv[8] = '{1'b1, 1,    5, 1'b1, 0,   -1, 1'b0, CRC_STARTS, 1, -1, -1};
    tv[9] = '{1'b0, 255,  2, 1'b0, 0,   -1, 1'b0, 255,        0, -1, -1};

    irst = 1'b1;
    repeat (3) @(negedge iclk);
    chk("reset_start_read", int'(odrv_start_read), 0);
    chk("reset_start_write", int'(odrv_start_write), 0);
    chk("reset_blk_idx", int'(oblk_idx), 0);
    chk("reset_busy", int'(obusy), 0);
    chk("reset_done", int'(odone), 0);
    chk("reset_err", int'(oerr), 0);
    irst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      cfg_delay = tv[i].delay;
      cfg_crc = tv[i].crc;
      cfg_busy = tv[i].busy;
      cfg_abort_idx = tv[i].abort_idx;
      @(negedge iclk);
      istart = 1'b1;
      iwrite = tv[i].wr;
      iblk_cnt = BW'(tv[i].cnt);
      base = done_cnt;
      sb.push_back('{tv[i].wr, tv[i].exp_starts, tv[i].exp_err, cyc, tv[i].exp_lat, tv[i].exp_to_lat});
      @(negedge iclk);
      istart = 1'b0;
      if (tv[i].mid_start) begin
        repeat (4) @(negedge iclk);
        chk("busy_mid_xfer", int'(obusy), 1);
        istart = 1'b1;
        iwrite = ~tv[i].wr;
        iblk_cnt = BW'(5);
        @(negedge iclk);
        istart = 1'b0;
      end
      budget = 0;
      while (done_cnt == base && budget < 20000) begin
        @(negedge iclk);
        budget++;
      end
      chk("xfer_completes", done_cnt - base, 1);
      repeat (20) @(negedge iclk);
      chk("no_starts_after_done", (n_rd + n_wr) - (snap_rd + snap_wr), 0);
      chk("idle_after_done", int'(obusy), 0);
      chk("err_held", int'(oerr), tv[i].exp_err);
      budget = 0;
      while (idat0 == 1'b0 && budget < 1000) begin
        @(negedge iclk);
        budget++;
      end
      chk("card_released", int'(idat0), 1);
    end

    cfg_delay = 10;
    cfg_crc = 1'b0;
    cfg_busy = 0;
    cfg_abort_idx = -1;
    @(negedge iclk);
    istart = 1'b1;
    iwrite = 1'b0;
    iblk_cnt = BW'(4);
    base = done_cnt;
    @(negedge iclk);
    istart = 1'b0;
    repeat (20) @(negedge iclk);
    chk("busy_before_reset", int'(obusy), 1);
    chk("idx_before_reset", int'(oblk_idx), 1);
    irst = 1'b1;
    @(negedge iclk);
    irst = 1'b0;
    chk("reset_mid_busy", int'(obusy), 0);
    chk("reset_mid_idx", int'(oblk_idx), 0);
    chk("reset_mid_done", int'(odone), 0);
    repeat (30) @(negedge iclk);
    chk("no_odone_after_reset", done_cnt - base, 0);
    chk("idle_after_reset", int'(obusy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
